// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package cpu_fetch_pkg;

    typedef enum logic [1:0] {
        REQ    = 2'd0,
        WAIT   = 2'd1,
        DROP   = 2'd2,
        HALTED = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

    localparam logic [OPCODE_MSB-OPCODE_LSB:0] HALT_OPCODE_DEFAULT = 6'h3F;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Small registered FIFO of {pc, instr} entries feeding decode.
module fetch_fifo
    import cpu_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = empty ? '0 : mem[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !clear) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem read at a time, results buffered toward decode.
module instr_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter  int                             FIFO_DEPTH  = 2,
    parameter  logic [OPCODE_MSB-OPCODE_LSB:0] HALT_OPCODE = HALT_OPCODE_DEFAULT,
    localparam int                             CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_value,
    output logic        fetch_stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        halt_seen
);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pending_pc_q, pending_pc_d;
    logic             halt_seen_q, halt_seen_d;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     fifo_in;
    fetch_entry_t     fifo_head;
    logic             req_accepted;

    // Request is suppressed during reset so nothing leaks out before state is known.
    assign imem_req     = (state_q == REQ) && !fifo_full && !reset;
    assign imem_addr    = pc_value;
    assign req_accepted = imem_req && imem_gnt;
    assign fetch_stall  = !req_accepted;

    assign if_valid  = (fifo_count != '0);
    assign fifo_pop  = if_ready && !fifo_empty;
    assign if_instr  = fifo_head.instr;
    assign if_pc     = fifo_head.pc;
    assign halt_seen = halt_seen_q;

    assign fifo_in.pc    = pending_pc_q;
    assign fifo_in.instr = imem_rdata;

    always_comb begin
        state_d      = state_q;
        pending_pc_d = pending_pc_q;
        halt_seen_d  = halt_seen_q;
        fifo_push    = 1'b0;
        unique case (state_q)
            REQ: begin
                if (req_accepted) begin
                    pending_pc_d = pc_value;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    fifo_push = 1'b1;
                    if (imem_rdata[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE) begin
                        state_d     = HALTED;
                        halt_seen_d = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = REQ;
            end
        endcase

        // A response still owed by memory must be swallowed after a redirect.
        if (flush) begin
            fifo_push   = 1'b0;
            halt_seen_d = 1'b0;
            if ((state_q == WAIT && !imem_rvalid) ||
                (state_q == REQ && req_accepted) ||
                (state_q == DROP)) begin
                state_d = DROP;
            end else begin
                state_d = REQ;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= REQ;
            pending_pc_q <= '0;
            halt_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_pc_q <= pending_pc_d;
            halt_seen_q  <= halt_seen_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (flush),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
